// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - parses ALU command packets from a UART byte stream
// into an opcode pulse plus a 32-bit operand stream; illegal packets are drained.
module uart_cmd_parser #(
  parameter int          DATA_WIDTH = 8,
  parameter int          WORD_WIDTH = 32,
  parameter logic [15:0] MAX_LEN    = 16'd1024,
  parameter logic [7:0]  OP_ADD     = 8'h10,
  parameter logic [7:0]  OP_MUL     = 8'h11,
  parameter logic [7:0]  OP_DIV     = 8'h12
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            cmd_opcode_o,
  output logic                  cmd_valid_o,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  pkt_error_o
);

  typedef enum logic [2:0] {
    ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DRAIN
  } state_t;

  state_t                         state_q, state_d;
  logic [7:0]                     opcode_q, opcode_d;
  logic [7:0]                     len_lo_q, len_lo_d;
  logic [15:0]                    remaining_q, remaining_d;
  logic [1:0]                     byte_cnt_q, byte_cnt_d;
  logic [WORD_WIDTH-DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]                     cmd_opcode_q, cmd_opcode_d;
  logic                           cmd_valid_q, cmd_valid_d;
  logic                           pkt_error_q, pkt_error_d;
  logic [WORD_WIDTH-1:0]          m_tdata_q, m_tdata_d;
  logic                           m_tvalid_q, m_tvalid_d;
  logic                           m_tlast_q, m_tlast_d;

  logic        ready_c;
  logic        accept_c;
  logic        legal_c;
  logic        last_pending_c;
  logic [15:0] len_c;

  assign len_c   = {s_axis_tdata[7:0], len_lo_q};
  assign legal_c = ((opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV)) &&
                   (len_c >= 16'd8) && (len_c <= MAX_LEN) && (len_c[1:0] == 2'b00);
  // A tlast word still waiting for the ALU blocks the next header from completing.
  assign last_pending_c = m_tvalid_q & m_tlast_q & ~m_axis_tready;

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_lo_d     = len_lo_q;
    remaining_d  = remaining_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_valid_d  = 1'b0;
    pkt_error_d  = 1'b0;
    m_tdata_d    = m_tdata_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    ready_c      = 1'b0;

    case (state_q)
      ST_LEN_HI: ready_c = ~last_pending_c;
      ST_DATA:   ready_c = ~m_tvalid_q | m_axis_tready;
      default:   ready_c = 1'b1;
    endcase
    accept_c = s_axis_tvalid & ready_c;

    if (m_tvalid_q && m_axis_tready) m_tvalid_d = 1'b0;

    if (accept_c) begin
      case (state_q)
        ST_OPCODE: begin
          opcode_d = s_axis_tdata[7:0];
          state_d  = ST_RSVD;
        end
        ST_RSVD:   state_d = ST_LEN_LO;
        ST_LEN_LO: begin
          len_lo_d = s_axis_tdata[7:0];
          state_d  = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          byte_cnt_d  = 2'd0;
          remaining_d = (len_c > 16'd4) ? (len_c - 16'd4) : 16'd0;
          if (legal_c) begin
            cmd_opcode_d = opcode_q;
            cmd_valid_d  = 1'b1;
            state_d      = ST_DATA;
          end else begin
            pkt_error_d = 1'b1;
            state_d     = (len_c <= 16'd4) ? ST_OPCODE : ST_DRAIN;
          end
        end
        ST_DATA: begin
          word_d      = {s_axis_tdata, word_q[WORD_WIDTH-DATA_WIDTH-1:DATA_WIDTH]};
          byte_cnt_d  = byte_cnt_q + 2'd1;
          remaining_d = remaining_q - 16'd1;
          if (byte_cnt_q == 2'd3) begin
            m_tdata_d  = {s_axis_tdata, word_q};
            m_tvalid_d = 1'b1;
            // remaining counts this byte, so 1 here means the word began with 4 left
            m_tlast_d  = (remaining_q == 16'd1);
          end
          if (remaining_q == 16'd1) state_d = ST_OPCODE;
        end
        ST_DRAIN: begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = ST_OPCODE;
        end
        default: state_d = ST_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_OPCODE;
      opcode_q     <= '0;
      len_lo_q     <= '0;
      remaining_q  <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      cmd_opcode_q <= '0;
      cmd_valid_q  <= 1'b0;
      pkt_error_q  <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_lo_q     <= len_lo_d;
      remaining_q  <= remaining_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_valid_q  <= cmd_valid_d;
      pkt_error_q  <= pkt_error_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  assign s_axis_tready = ready_c & ~reset_i;
  assign cmd_opcode_o  = cmd_opcode_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign pkt_error_o   = pkt_error_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser: directed packets,
// expectations queued at issue time, checked by an independent output monitor.
module tb_uart_cmd_parser;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  cmd_opcode_o;
  logic        cmd_valid_o;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        pkt_error_o;

  uart_cmd_parser dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .cmd_opcode_o  (cmd_opcode_o),
    .cmd_valid_o   (cmd_valid_o),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_error_o   (pkt_error_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  int          exp_err = 0;
  int          err_seen = 0;
  logic [32:0] exp_w[$];
  logic [7:0]  exp_cmd[$];
  logic [31:0] ops[8];

  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk_i) begin
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total++;
        if (!(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last)) begin
          bad++;
          $display("FAIL hold_stable got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        total++;
        if (exp_w.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word got d=%h l=%b required none", m_axis_tdata, m_axis_tlast);
        end else begin
          logic [32:0] e;
          e = exp_w.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            bad++;
            $display("FAIL word got d=%h l=%b required d=%h l=%b",
                     m_axis_tdata, m_axis_tlast, e[31:0], e[32]);
          end
        end
      end
      if (cmd_valid_o) begin
        total++;
        if (exp_cmd.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd got op=%h required none", cmd_opcode_o);
        end else begin
          logic [7:0] eo;
          eo = exp_cmd.pop_front();
          if (cmd_opcode_o !== eo) begin
            bad++;
            $display("FAIL cmd_opcode got %h required %h", cmd_opcode_o, eo);
          end
        end
        total++;
        if (m_axis_tvalid && m_axis_tlast) begin
          bad++;
          $display("FAIL cmd_before_tlast got pending tlast=1 required 0");
        end
      end
      if (pkt_error_o) begin
        total++;
        if (err_seen >= exp_err) begin
          bad++;
          $display("FAIL unexpected_error got errors=%0d required %0d", err_seen + 1, exp_err);
        end
        err_seen++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Called from just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int c;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    c = 0;
    @(negedge clk_i);
    while (!s_axis_tready && c < 300) begin
      @(negedge clk_i);
      c++;
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout byte=%h got ready=0 required 1", b);
    end
    @(posedge clk_i);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic legal_pkt(input logic [7:0] op, input int n);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(4 + 4 * n);
    exp_cmd.push_back(op);
    for (int i = 0; i < n; i++) exp_w.push_back({(i == n - 1), ops[i]});
    send_hdr(op, len);
    for (int i = 0; i < n; i++) begin
      w = ops[i];
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
    end
  endtask

  task automatic bad_pkt(input logic [7:0] op, input logic [15:0] len);
    exp_err++;
    send_hdr(op, len);
    for (int i = 0; i < int'(len) - 4; i++) send_byte(8'(i));
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, cmd_valid_o, pkt_error_o} !== 5'b0) begin
      bad++;
      $display("FAIL %s_ctrl got rdy/v/l/cv/err=%b required 00000", name,
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, cmd_valid_o, pkt_error_o});
    end
    total++;
    if ({cmd_opcode_o, m_axis_tdata} !== 40'b0) begin
      bad++;
      $display("FAIL %s_data got op=%h d=%h required 0", name, cmd_opcode_o, m_axis_tdata);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b1;
    @(negedge clk_i);
    check_all_zero("por");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got %b required 1", s_axis_tready);
    end
    @(posedge clk_i);
    #1;

    // Basic ADD, len=12.
    ops[0] = 32'h0000_0005;
    ops[1] = 32'h0000_0007;
    legal_pkt(8'h10, 2);

    // Output stall mid-packet.
    ops[0] = 32'h1122_3344;
    ops[1] = 32'hAABB_CCDD;
    ops[2] = 32'h0102_0304;
    fork
      legal_pkt(8'h11, 3);
      begin
        int c;
        c = 0;
        while (!m_axis_tvalid && c < 200) begin
          @(negedge clk_i);
          c++;
        end
        @(posedge clk_i);
        #1;
        m_axis_tready = 1'b0;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (s_axis_tready !== 1'b0) begin
          bad++;
          $display("FAIL stall_backpressure got ready=%b required 0", s_axis_tready);
        end
        @(posedge clk_i);
        #1;
        m_axis_tready = 1'b1;
      end
    join

    // Illegal opcode drained, then a legal packet.
    bad_pkt(8'h55, 16'd12);
    ops[0] = 32'hDEAD_BEEF;
    legal_pkt(8'h12, 1);

    // Length not a multiple of 4, and length above MAX_LEN.
    bad_pkt(8'h10, 16'd10);
    bad_pkt(8'h11, 16'd2000);
    ops[0] = 32'h1234_5678;
    legal_pkt(8'h10, 1);

    // Back-to-back with the ALU always ready.
    ops[0] = 32'hCAFE_0001;
    legal_pkt(8'h10, 1);
    ops[0] = 32'h0000_00FF;
    ops[1] = 32'hFFFF_0000;
    legal_pkt(8'h11, 2);

    // Back-to-back with the last operand held: next header must wait.
    m_axis_tready = 1'b0;
    fork
      begin
        ops[0] = 32'h0BAD_F00D;
        legal_pkt(8'h12, 1);
        ops[0] = 32'h7777_8888;
        legal_pkt(8'h10, 1);
      end
      begin
        repeat (30) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (s_axis_tready !== 1'b0) begin
          bad++;
          $display("FAIL len_hi_hold got ready=%b required 0", s_axis_tready);
        end
        @(posedge clk_i);
        #1;
        m_axis_tready = 1'b1;
      end
    join

    // Reset in DATA after two operand bytes.
    exp_cmd.push_back(8'h10);
    send_hdr(8'h10, 16'd12);
    send_byte(8'hA1);
    send_byte(8'hA2);
    do_reset();
    @(posedge clk_i);
    #1;
    ops[0] = 32'h5555_AAAA;
    legal_pkt(8'h11, 1);

    repeat (10) @(negedge clk_i);
    total++;
    if (exp_w.size() != 0) begin
      bad++;
      $display("FAIL words_left got %0d required 0", exp_w.size());
    end
    total++;
    if (exp_cmd.size() != 0) begin
      bad++;
      $display("FAIL cmds_left got %0d required 0", exp_cmd.size());
    end
    total++;
    if (err_seen != exp_err) begin
      bad++;
      $display("FAIL error_count got %0d required %0d", err_seen, exp_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
